// File: rtl/fxp_mult_pkg.sv
// fxp_mult_pkg: shared state encoding and digit-count helper for the radix multiplier.
package fxp_mult_pkg;
  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE} state_t;
  function automatic int num_digits(input int n, input int k);
    return (n + k - 1) / k;
  endfunction
endpackage

// File: rtl/fxp_mult_digit_pp.sv
// fxp_mult_digit_pp: shifted partial product of one K-bit multiplier digit.
module fxp_mult_digit_pp
  import fxp_mult_pkg::*;
#(
  parameter int N = 32,
  parameter int K = 2,
  parameter int IW = 2
) (
  input  logic [N-1:0]   mcand,
  input  logic [K-1:0]   digit,
  input  logic [IW-1:0]  idx,
  input  logic           signed_mode,
  output logic [2*N-1:0] pp
);
  localparam int L = num_digits(N, K);
  logic [2*N-1:0] a_x;
  logic [2*N-1:0] d_x;
  logic neg;
  // only the top digit carries the sign weight of a two's-complement multiplier
  always_comb begin
    a_x = {2*N{signed_mode & mcand[N-1]}};
    a_x[N-1:0] = mcand;
    d_x = '0;
    d_x[K-1:0] = digit;
    neg = signed_mode && idx == IW'(L - 1) && digit[K-1];
    pp = ((a_x * d_x) - (neg ? a_x << K : '0)) << (idx * K);
  end
endmodule

// File: rtl/fxp_radix_multiplier.sv
// fxp_radix_multiplier: radix-2^K iterative Q-format multiplier with val/rdy handshake.
// FXP_MULT_ROUND_EN selects round-half-up instead of truncation.
module fxp_radix_multiplier
  import fxp_mult_pkg::*;
#(
  parameter int N = 32,
  parameter int D = 16,
  parameter int K = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         recv_val,
  output logic         recv_rdy,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         signed_mode,
  input  logic         send_rdy,
  output logic         send_val,
  output logic [N-1:0] c,
  output logic         ovf
);
  localparam int L = num_digits(N, K);
  localparam int CW = $clog2(L + 1);
  localparam int LK = L * K;
`ifdef FXP_MULT_ROUND_EN
  localparam logic [2*N-1:0] rnd = (2*N)'(1) << (D - 1);
`else
  localparam logic [2*N-1:0] rnd = '0;
`endif
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] a_q;
  logic [LK-1:0] b_q, b_x;
  logic mode, last, ovf_n;
  logic [2*N-1:0] acc, pp, p, p_sh;
  logic signed [2*N-1:0] p_s;
  logic [N:0] hi;
  fxp_mult_digit_pp #(.N(N), .K(K), .IW(CW)) u_pp (
    .mcand(a_q),
    .digit(b_q[cnt*K +: K]),
    .idx(cnt),
    .signed_mode(mode),
    .pp(pp)
  );
  assign recv_rdy = state == IDLE;
  assign send_val = state == DONE;
  assign last = cnt == CW'(L - 1);
  always_comb begin
    state_n = (state == IDLE && recv_val) ? CALC :
              (state == CALC && last) ? FINAL :
              (state == FINAL) ? DONE :
              (state == DONE && send_rdy) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  // multiplier is widened to whole digits so the top digit is zero/sign-extended
  always_comb begin
    b_x = {LK{signed_mode & b[N-1]}};
    b_x[N-1:0] = b;
    p = acc + rnd;
    p_s = $signed(p) >>> D;
    p_sh = mode ? p_s : p >> D;
    hi = p_sh[2*N-1:N-1];
    ovf_n = mode ? (|hi & ~&hi) : |p_sh[2*N-1:N];
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      c <= '0;
      ovf <= 1'b0;
    end else if (state == IDLE && recv_val) begin
      a_q <= a;
      b_q <= b_x;
      mode <= signed_mode;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      acc <= acc + pp;
      cnt <= last ? '0 : cnt + 1'b1;
    end else if (state == FINAL) begin
      c <= p_sh[N-1:0];
      ovf <= ovf_n;
    end
  end
endmodule

// File: tb/tb_fxp_radix_multiplier.sv
// tb_fxp_radix_multiplier: vector table, corner sequences and random checks for K=2 and K=3 units.
module tb_fxp_radix_multiplier;
  localparam int N = 16;
  localparam int D = 8;
`ifdef FXP_MULT_ROUND_EN
  localparam logic [N-1:0] rnd_c = 16'h0001;
`else
  localparam logic [N-1:0] rnd_c = 16'h0000;
`endif
  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic sm;
    logic [N-1:0] c;
    logic o;
    string nm;
  } vec_t;
  logic clk = 0;
  logic reset = 0;
  logic [1:0] recv_val = '0, signed_mode = '0, send_rdy = '0;
  logic [1:0] recv_rdy, send_val, ovf;
  logic [1:0][N-1:0] a = '0, b = '0, c;
  int n_cmp = 0, n_bad = 0;
  int lat_exp[2] = '{9, 7};
  vec_t tv[6];
  always #5 clk = ~clk;
  fxp_radix_multiplier #(.N(N), .D(D), .K(2)) u0 (
    .clk(clk), .reset(reset), .recv_val(recv_val[0]), .recv_rdy(recv_rdy[0]),
    .a(a[0]), .b(b[0]), .signed_mode(signed_mode[0]), .send_rdy(send_rdy[0]),
    .send_val(send_val[0]), .c(c[0]), .ovf(ovf[0])
  );
  fxp_radix_multiplier #(.N(N), .D(D), .K(3)) u1 (
    .clk(clk), .reset(reset), .recv_val(recv_val[1]), .recv_rdy(recv_rdy[1]),
    .a(a[1]), .b(b[1]), .signed_mode(signed_mode[1]), .send_rdy(send_rdy[1]),
    .send_val(send_val[1]), .c(c[1]), .ovf(ovf[1])
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // exact integer product, optionally rounded, then floor-shifted and range-checked
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic sm);
    longint p, r;
    logic o;
    p = sm ? longint'($signed(x)) * longint'($signed(y)) : longint'(x) * longint'(y);
`ifdef FXP_MULT_ROUND_EN
    p = p + (longint'(1) << (D - 1));
`endif
    r = p >>> D;
    o = sm ? (r < -(longint'(1) << (N - 1)) || r > (longint'(1) << (N - 1)) - 1)
           : (r > (longint'(1) << N) - 1);
    return {o, r[N-1:0]};
  endfunction
  task automatic run(input int u, input logic [N-1:0] x, input logic [N-1:0] y, input logic sm,
                     output logic [N-1:0] rc, output logic ro, output int lat);
    int w = 0;
    while (!recv_rdy[u] && w < 50) begin
      @(negedge clk);
      w++;
    end
    recv_val[u] = 1; a[u] = x; b[u] = y; signed_mode[u] = sm;
    @(posedge clk);
    @(negedge clk);
    recv_val[u] = 0; a[u] = ~x; b[u] = N'($urandom); signed_mode[u] = ~sm;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!send_val[u] && lat < 100);
    rc = c[u];
    ro = ovf[u];
    send_rdy[u] = 1;
    @(posedge clk);
    @(negedge clk);
    send_rdy[u] = 0;
  endtask
  task automatic txn(input int u, input string nm, input logic [N-1:0] x, input logic [N-1:0] y,
                     input logic sm, input logic [N-1:0] ec, input logic eo);
    logic [N-1:0] rc;
    logic ro;
    int lat;
    run(u, x, y, sm, rc, ro, lat);
    chk({nm, ".c"}, 64'(rc), 64'(ec));
    chk({nm, ".ovf"}, 64'(ro), 64'(eo));
    chk({nm, ".lat"}, 64'(lat), 64'(lat_exp[u]));
  endtask
  initial begin
    logic [N:0] m;
    logic [N-1:0] x, y;
    logic sm;
    int w;
    tv[0] = '{16'h0180, 16'h0240, 1'b0, 16'h0360, 1'b0, "u_1p5x2p25"};
    tv[1] = '{16'hFE80, 16'h0200, 1'b1, 16'hFD00, 1'b0, "s_m1p5x2"};
    tv[2] = '{16'hFF00, 16'h0200, 1'b1, 16'hFE00, 1'b0, "s_m1x2"};
    tv[3] = '{16'hFF00, 16'h0200, 1'b0, 16'hFE00, 1'b1, "u_ovf"};
    tv[4] = '{16'h7F00, 16'h0200, 1'b1, 16'hFE00, 1'b1, "s_ovf"};
    tv[5] = '{16'h0001, 16'h0080, 1'b0, rnd_c, 1'b0, "round"};
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst%0d.recv_rdy", u), 64'(recv_rdy[u]), 64'd1);
      chk($sformatf("rst%0d.send_val", u), 64'(send_val[u]), 64'd0);
      chk($sformatf("rst%0d.c", u), 64'(c[u]), 64'd0);
      chk($sformatf("rst%0d.ovf", u), 64'(ovf[u]), 64'd0);
    end
    for (int i = 0; i < 6; i++) txn(0, tv[i].nm, tv[i].x, tv[i].y, tv[i].sm, tv[i].c, tv[i].o);
    for (int i = 0; i < 4; i++) txn(1, {"k3_", tv[i].nm}, tv[i].x, tv[i].y, tv[i].sm, tv[i].c, tv[i].o);
    // backpressure: result held while consumer stalls; operands offered meanwhile are ignored
    recv_val[0] = 1; a[0] = tv[0].x; b[0] = tv[0].y; signed_mode[0] = 0;
    @(posedge clk);
    @(negedge clk);
    recv_val[0] = 0;
    w = 0;
    while (!send_val[0] && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("bp.reach_done", 64'(send_val[0]), 64'd1);
    recv_val[0] = 1; a[0] = 16'h7FFF; b[0] = 16'h7FFF; signed_mode[0] = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.send_val", 64'(send_val[0]), 64'd1);
      chk("bp.c", 64'(c[0]), 64'h0360);
      chk("bp.ovf", 64'(ovf[0]), 64'd0);
      chk("bp.recv_rdy", 64'(recv_rdy[0]), 64'd0);
    end
    recv_val[0] = 0;
    send_rdy[0] = 1;
    @(posedge clk);
    @(negedge clk);
    send_rdy[0] = 0;
    chk("bp.release_send_val", 64'(send_val[0]), 64'd0);
    chk("bp.release_recv_rdy", 64'(recv_rdy[0]), 64'd1);
    txn(0, "bp.next", tv[1].x, tv[1].y, 1'b1, tv[1].c, tv[1].o);
    // reset asserted in the third CALC cycle discards the transaction
    recv_val[0] = 1; a[0] = 16'h0300; b[0] = 16'h0500; signed_mode[0] = 0;
    @(posedge clk);
    @(negedge clk);
    recv_val[0] = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rstcalc.send_val", 64'(send_val[0]), 64'd0);
    chk("rstcalc.c", 64'(c[0]), 64'd0);
    chk("rstcalc.ovf", 64'(ovf[0]), 64'd0);
    reset = 1;
    @(negedge clk);
    chk("rstcalc.recv_rdy", 64'(recv_rdy[0]), 64'd1);
    chk("rstcalc.idle_send_val", 64'(send_val[0]), 64'd0);
    txn(0, "rstcalc.next", 16'h0300, 16'h0500, 1'b0, 16'h0F00, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      x = N'($urandom); y = N'($urandom); sm = 1'($urandom_range(0, 1));
      m = model(x, y, sm);
      txn(1, $sformatf("rnd_k3_%0d", i), x, y, sm, m[N-1:0], m[N]);
    end
    for (int i = 0; i < 200; i++) begin
      x = N'($urandom); y = N'($urandom); sm = 1'($urandom_range(0, 1));
      m = model(x, y, sm);
      txn(0, $sformatf("rnd_k2_%0d", i), x, y, sm, m[N-1:0], m[N]);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
